// File: rtl/regfile_wb_arbiter.sv
// Two-requester writeback arbiter for the single register-file write port.
// Optional staged-write forwarding compare is enabled with WB_ARB_FWD_EN.
module regfile_wb_arbiter #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_WAIT   = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  a_valid_i,
   input  logic [ADDR_WIDTH-1:0] a_addr_i,
   input  logic [DATA_WIDTH-1:0] a_data_i,
   output logic                  a_ready_o,
   input  logic                  b_valid_i,
   input  logic [ADDR_WIDTH-1:0] b_addr_i,
   input  logic [DATA_WIDTH-1:0] b_data_i,
   output logic                  b_ready_o,
`ifdef WB_ARB_FWD_EN
   input  logic [ADDR_WIDTH-1:0] fwd_addr1_i,
   input  logic [ADDR_WIDTH-1:0] fwd_addr2_i,
   output logic                  fwd_hit1_o,
   output logic                  fwd_hit2_o,
   output logic [DATA_WIDTH-1:0] fwd_data_o,
`endif
   output logic                  we_o,
   output logic [ADDR_WIDTH-1:0] wr_addr_o,
   output logic [DATA_WIDTH-1:0] wr_data_o,
   output logic                  b_starved_o
);

   localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

   logic [3:0] wait_cnt;
   logic       stage_vld;
   logic       force_b;
   logic       grant_a;
   logic       grant_b;

   // Mode is implied by wait_cnt: below WAIT_MAX A has priority, at WAIT_MAX B is forced.
   always_comb begin
      force_b = b_valid_i && (wait_cnt == WAIT_MAX);
      grant_a = a_valid_i && !force_b;
      grant_b = b_valid_i && !grant_a;
   end

   assign a_ready_o   = rst_n && grant_a;
   assign b_ready_o   = rst_n && grant_b;
   assign b_starved_o = (wait_cnt == WAIT_MAX);
   assign we_o        = stage_vld && (wr_addr_o != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= 4'd0;
      end else if (grant_b || !b_valid_i) begin
         wait_cnt <= 4'd0;
      end else if (wait_cnt != WAIT_MAX) begin
         wait_cnt <= wait_cnt + 4'd1;
      end
   end

   // Address/data hold when idle so forwarding compares stay quiet but stable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage_vld <= 1'b0;
         wr_addr_o <= '0;
         wr_data_o <= '0;
      end else begin
         stage_vld <= grant_a || grant_b;
         if (grant_a) begin
            wr_addr_o <= a_addr_i;
            wr_data_o <= a_data_i;
         end else if (grant_b) begin
            wr_addr_o <= b_addr_i;
            wr_data_o <= b_data_i;
         end
      end
   end

`ifdef WB_ARB_FWD_EN
   assign fwd_hit1_o = we_o && (fwd_addr1_i == wr_addr_o);
   assign fwd_hit2_o = we_o && (fwd_addr2_i == wr_addr_o);
   assign fwd_data_o = wr_data_o;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios followed by
// randomized traffic compared against a cycle-level behavioural model.
module tb_regfile_wb_arbiter;
   localparam int AW = 5;
   localparam int DW = 32;
   localparam int MW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          a_valid, b_valid;
   logic [AW-1:0] a_addr, b_addr;
   logic [DW-1:0] a_data, b_data;
   logic          a_ready, b_ready, we, b_starved;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
`ifdef WB_ARB_FWD_EN
   logic [AW-1:0] fwd_addr1, fwd_addr2;
   logic          fwd_hit1, fwd_hit2;
   logic [DW-1:0] fwd_data;
`endif

   always #5 clk = ~clk;

   regfile_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_valid_i(a_valid), .a_addr_i(a_addr), .a_data_i(a_data), .a_ready_o(a_ready),
      .b_valid_i(b_valid), .b_addr_i(b_addr), .b_data_i(b_data), .b_ready_o(b_ready),
`ifdef WB_ARB_FWD_EN
      .fwd_addr1_i(fwd_addr1), .fwd_addr2_i(fwd_addr2),
      .fwd_hit1_o(fwd_hit1), .fwd_hit2_o(fwd_hit2), .fwd_data_o(fwd_data),
`endif
      .we_o(we), .wr_addr_o(wr_addr), .wr_data_o(wr_data), .b_starved_o(b_starved)
   );

   int n_pass = 0;
   int n_total = 0;

   // Reference model: number of consecutive cycles B has been refused, plus the staged write.
   int            m_refused;
   bit            m_sv;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;
   bit            exp_ga, exp_gb;
   logic          seen_bready;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_refused = 0;
      m_sv      = 1'b0;
      m_addr    = '0;
      m_data    = '0;
   endtask

   // One clock: drive, check combinational readies, clock, update model, check stage.
   task automatic cycle(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                        input logic bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
      bit forced;
      a_valid = av; a_addr = aa; a_data = ad;
      b_valid = bv; b_addr = ba; b_data = bd;
      #1;
      forced = bv && (m_refused >= MW);
      exp_ga = av && !forced;
      exp_gb = bv && !exp_ga;
      seen_bready = b_ready;
      chk("a_ready", 64'(a_ready), 64'(exp_ga));
      chk("b_ready", 64'(b_ready), 64'(exp_gb));
      chk("b_starved", 64'(b_starved), 64'(m_refused >= MW));
      @(posedge clk);
      #1;
      if (!bv || exp_gb) m_refused = 0;
      else if (m_refused < MW) m_refused++;
      m_sv = exp_ga || exp_gb;
      if (exp_ga) begin m_addr = aa; m_data = ad; end
      else if (exp_gb) begin m_addr = ba; m_data = bd; end
      chk("we", 64'(we), 64'(m_sv && (m_addr != '0)));
      chk("wr_addr", 64'(wr_addr), 64'(m_addr));
      chk("wr_data", 64'(wr_data), 64'(m_data));
   endtask

   initial begin
      logic          pa_v, pb_v;
      logic [AW-1:0] pa_a, pb_a;
      logic [DW-1:0] pa_d, pb_d;

      rst_n = 1'b0;
      a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h1;
      b_valid = 1'b1; b_addr = 5'd4; b_data = 32'h2;
`ifdef WB_ARB_FWD_EN
      fwd_addr1 = '0; fwd_addr2 = '0;
`endif
      model_reset();
      #2;
      chk("rst_a_ready", 64'(a_ready), 64'd0);
      chk("rst_b_ready", 64'(b_ready), 64'd0);
      chk("rst_we", 64'(we), 64'd0);
      chk("rst_starved", 64'(b_starved), 64'd0);
      chk("rst_wr_addr", 64'(wr_addr), 64'd0);
      chk("rst_wr_data", 64'(wr_data), 64'd0);
      a_valid = 1'b0; b_valid = 1'b0;
      #10 rst_n = 1'b1;

      // A alone
      cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
      chk("a_alone_we", 64'(we), 64'd1);
      chk("a_alone_addr", 64'(wr_addr), 64'd5);
      chk("a_alone_data", 64'(wr_data), 64'hDEADBEEF);
      cycle(1'b0, '0, '0, 1'b0, '0, '0);
      chk("a_alone_we_drop", 64'(we), 64'd0);

      // Both valid: AAAAB repeating
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, AW'(i + 1), DW'(i * 16 + 3), 1'b1, 5'd20, DW'(32'hB000 + i / 5));
         chk("aaaab_pattern", 64'(seen_bready), 64'((i % 5) == 4));
      end
      cycle(1'b0, '0, '0, 1'b0, '0, '0);

      // B alone
      cycle(1'b0, '0, '0, 1'b1, 5'd12, 32'h1234);
      chk("b_alone_we", 64'(we), 64'd1);
      chk("b_alone_addr", 64'(wr_addr), 64'd12);
      chk("b_alone_starved", 64'(b_starved), 64'd0);

      // Write to x0 is accepted but never written
      cycle(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, '0, '0);
      chk("x0_we", 64'(we), 64'd0);
      cycle(1'b0, '0, '0, 1'b0, '0, '0);
      chk("x0_we_after", 64'(we), 64'd0);

      // Reset while a write is staged
      cycle(1'b1, 5'd9, 32'hCAFE0009, 1'b1, 5'd10, 32'h0A);
      chk("pre_rst_we", 64'(we), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_we", 64'(we), 64'd0);
      chk("mid_rst_a_ready", 64'(a_ready), 64'd0);
      chk("mid_rst_b_ready", 64'(b_ready), 64'd0);
      chk("mid_rst_starved", 64'(b_starved), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      model_reset();
      cycle(1'b1, 5'd9, 32'hCAFE0009, 1'b0, '0, '0);
      chk("post_rst_addr", 64'(wr_addr), 64'd9);
      chk("post_rst_data", 64'(wr_data), 64'hCAFE0009);

`ifdef WB_ARB_FWD_EN
      fwd_addr1 = 5'd7; fwd_addr2 = 5'd8;
      cycle(1'b1, 5'd7, 32'h55, 1'b0, '0, '0);
      chk("fwd_hit1", 64'(fwd_hit1), 64'd1);
      chk("fwd_hit2", 64'(fwd_hit2), 64'd0);
      chk("fwd_data", 64'(fwd_data), 64'h55);
      fwd_addr1 = 5'd0; fwd_addr2 = 5'd0;
      cycle(1'b1, 5'd0, 32'h66, 1'b0, '0, '0);
      chk("fwd_x0_hit1", 64'(fwd_hit1), 64'd0);
      chk("fwd_x0_hit2", 64'(fwd_hit2), 64'd0);
`endif

      // Random traffic; each requester holds its write until accepted
      pa_v = 1'b0; pb_v = 1'b0;
      pa_a = '0; pb_a = '0; pa_d = '0; pb_d = '0;
      for (int i = 0; i < 400; i++) begin
         if (!pa_v) begin
            pa_v = ($urandom_range(0, 99) < 70);
            pa_a = AW'($urandom_range(0, 31));
            pa_d = DW'($urandom());
         end
         if (!pb_v) begin
            pb_v = ($urandom_range(0, 99) < 60);
            pb_a = AW'($urandom_range(0, 31));
            pb_d = DW'($urandom());
         end
         cycle(pa_v, pa_a, pa_d, pb_v, pb_a, pb_d);
         if (exp_ga) pa_v = 1'b0;
         if (exp_gb) pb_v = 1'b0;
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
